// File: rtl/matmul_pkg.sv
// matmul shared constants, state encoding and address helper.
// Row-major 16x16 layout: element [r][c] lives at r*N+c.
package matmul_pkg;

    localparam int N      = 16;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int IDX_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    typedef logic [IDX_W-1:0] idx_t;

    function automatic logic [ADDR_W-1:0] addr_of(
        input idx_t row,
        input idx_t col
    );
        return ADDR_W'(row) * ADDR_W'(N) + ADDR_W'(col);
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// matmul multiply-accumulate: 32-bit product and sum, both modulo 2^32.
// clr wins over en; the accumulator is the C write data.
import matmul_pkg::*;

module matmul_mac (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] acc
);

    logic [DATA_W-1:0] prod;

    assign prod = a * b;

    // clear at element start, otherwise add the returned product
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod;
        end
    end

endmodule

// File: rtl/matmul.sv
// matmul top: FSM, i/j/k counters and registered memory ports.
// One MAC per cycle; 18 cycles per C element, 4609 cycles per run.
import matmul_pkg::*;

module matmul (
    input  logic              clk,
    input  logic              rst,
    input  logic              t,
    output logic [ADDR_W-1:0] Ai_p0_addr_data,
    output logic              Ai_p0_addr_en,
    output logic              Ai_p0_rd_en,
    input  logic [DATA_W-1:0] Ai_p0_rd_data,
    output logic [ADDR_W-1:0] Bi_p0_addr_data,
    output logic              Bi_p0_addr_en,
    output logic              Bi_p0_rd_en,
    input  logic [DATA_W-1:0] Bi_p0_rd_data,
    output logic [ADDR_W-1:0] Co_p0_addr_data,
    output logic              Co_p0_addr_en,
    output logic              Co_p0_wr_en,
    output logic [DATA_W-1:0] Co_p0_wr_data,
    output logic              done
);

    localparam idx_t LAST = idx_t'(N - 1);

    state_t state, state_n;
    idx_t   i, j, k;
    idx_t   i_n, j_n, k_n;
    logic   rd_q;

    logic              rd_en_n;
    logic              wr_en_n;
    logic              done_n;
    logic [ADDR_W-1:0] a_addr_n;
    logic [ADDR_W-1:0] b_addr_n;
    logic [ADDR_W-1:0] c_addr_n;

    logic mac_clr;

    // state and loop counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
        end else begin
            state <= state_n;
            i     <= i_n;
            j     <= j_n;
            k     <= k_n;
        end
    end

    // next state and counter advance; i/j wrap to 0 after (15,15)
    always_comb begin
        state_n = state;
        i_n     = i;
        j_n     = j;
        k_n     = k;
        unique case (state)
            IDLE: begin
                if (t) begin
                    state_n = ISSUE;
                    k_n     = '0;
                end
            end
            ISSUE: begin
                if (k == LAST) begin
                    state_n = DRAIN;
                    k_n     = '0;
                end else begin
                    k_n = k + 1'b1;
                end
            end
            DRAIN: begin
                state_n = WRITE;
            end
            WRITE: begin
                j_n = j + 1'b1;
                if (j == LAST) begin
                    i_n = i + 1'b1;
                end
                if (i == LAST && j == LAST) begin
                    state_n = DONE;
                end else begin
                    state_n = ISSUE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // port values for the coming cycle, so every port is a flop output
    always_comb begin
        rd_en_n  = (state_n == ISSUE);
        wr_en_n  = (state_n == WRITE);
        done_n   = (state_n == DONE);
        a_addr_n = addr_of(i_n, k_n);
        b_addr_n = addr_of(k_n, j_n);
        c_addr_n = addr_of(i_n, j_n);
    end

    // port registers; rd_q marks the cycle where read data is valid
    always_ff @(posedge clk) begin
        if (!rst) begin
            Ai_p0_rd_en     <= 1'b0;
            Bi_p0_rd_en     <= 1'b0;
            Ai_p0_addr_data <= '0;
            Bi_p0_addr_data <= '0;
            Co_p0_wr_en     <= 1'b0;
            Co_p0_addr_data <= '0;
            done            <= 1'b0;
            rd_q            <= 1'b0;
        end else begin
            Ai_p0_rd_en     <= rd_en_n;
            Bi_p0_rd_en     <= rd_en_n;
            Ai_p0_addr_data <= a_addr_n;
            Bi_p0_addr_data <= b_addr_n;
            Co_p0_wr_en     <= wr_en_n;
            Co_p0_addr_data <= c_addr_n;
            done            <= done_n;
            rd_q            <= Ai_p0_rd_en;
        end
    end

    assign Ai_p0_addr_en = Ai_p0_rd_en;
    assign Bi_p0_addr_en = Bi_p0_rd_en;
    assign Co_p0_addr_en = Co_p0_wr_en;

    assign mac_clr = (state == ISSUE) && (k == '0);

    matmul_mac u_mac (
        .clk (clk),
        .rst (rst),
        .clr (mac_clr),
        .en  (rd_q),
        .a   (Ai_p0_rd_data),
        .b   (Bi_p0_rd_data),
        .acc (Co_p0_wr_data)
    );

endmodule

// File: tb/tb_matmul.sv
// tb_matmul: memory models, write/done logger and scenario tasks.
// Expected C comes from a plain triple-loop product of the A/B arrays.
module tb_matmul;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        t   = 1'b0;
    logic [7:0]  Ai_p0_addr_data, Bi_p0_addr_data, Co_p0_addr_data;
    logic        Ai_p0_addr_en, Ai_p0_rd_en;
    logic        Bi_p0_addr_en, Bi_p0_rd_en;
    logic        Co_p0_addr_en, Co_p0_wr_en;
    logic [31:0] Ai_p0_rd_data, Bi_p0_rd_data, Co_p0_wr_data;
    logic        done;

    int total = 0;
    int bad   = 0;

    logic [31:0] amem [256];
    logic [31:0] bmem [256];
    logic [31:0] cmem [256];
    logic [31:0] cref [256];

    int cyc = 0;
    int t0  = 0;
    int wr_addr [$];
    int wr_cyc  [$];
    int done_q  [$];
    int rd_cnt  = 0;
    int en_bad  = 0;

    matmul dut (
        .clk             (clk),
        .rst             (rst),
        .t               (t),
        .Ai_p0_addr_data (Ai_p0_addr_data),
        .Ai_p0_addr_en   (Ai_p0_addr_en),
        .Ai_p0_rd_en     (Ai_p0_rd_en),
        .Ai_p0_rd_data   (Ai_p0_rd_data),
        .Bi_p0_addr_data (Bi_p0_addr_data),
        .Bi_p0_addr_en   (Bi_p0_addr_en),
        .Bi_p0_rd_en     (Bi_p0_rd_en),
        .Bi_p0_rd_data   (Bi_p0_rd_data),
        .Co_p0_addr_data (Co_p0_addr_data),
        .Co_p0_addr_en   (Co_p0_addr_en),
        .Co_p0_wr_en     (Co_p0_wr_en),
        .Co_p0_wr_data   (Co_p0_wr_data),
        .done            (done)
    );

    always #5 clk = ~clk;

    // synchronous memories: registered read, write captured at the edge
    always @(posedge clk) begin
        if (Ai_p0_rd_en) Ai_p0_rd_data <= amem[Ai_p0_addr_data];
        if (Bi_p0_rd_en) Bi_p0_rd_data <= bmem[Bi_p0_addr_data];
        if (Co_p0_wr_en) cmem[Co_p0_addr_data] <= Co_p0_wr_data;
        cyc <= cyc + 1;
    end

    // logger: cycle numbers are relative to the cycle that raised t
    always @(negedge clk) begin
        if (Co_p0_wr_en) begin
            wr_addr.push_back(int'(Co_p0_addr_data));
            wr_cyc.push_back(cyc - t0);
        end
        if (done) done_q.push_back(cyc - t0);
        if (Ai_p0_rd_en) rd_cnt++;
        if (Ai_p0_addr_en !== Ai_p0_rd_en || Bi_p0_addr_en !== Bi_p0_rd_en ||
            Co_p0_addr_en !== Co_p0_wr_en || Ai_p0_rd_en !== Bi_p0_rd_en)
            en_bad++;
    end

    task automatic compute_ref();
        logic [31:0] s;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                s = 32'd0;
                for (int x = 0; x < 16; x++)
                    s = s + amem[r*16+x] * bmem[x*16+c];
                cref[r*16+c] = s;
            end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_cyc.delete();
        done_q.delete();
        rd_cnt = 0;
        en_bad = 0;
        for (int n = 0; n < 256; n++) cmem[n] = 32'hDEAD_BEEF;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        t  = 1'b1;
        t0 = cyc;
        @(negedge clk);
        t = 1'b0;
    endtask

    task automatic wait_done(input int want, input int budget);
        int n = 0;
        while (done_q.size() < want && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic fill_random();
        for (int n = 0; n < 256; n++) begin
            amem[n] = $urandom;
            bmem[n] = $urandom;
        end
    endtask

    task automatic fill_const(input logic [31:0] va, input logic [31:0] vb);
        for (int n = 0; n < 256; n++) begin
            amem[n] = va;
            bmem[n] = vb;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (Ai_p0_rd_en !== 1'b0 || Bi_p0_rd_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_rd_en got=%b%b want=00", Ai_p0_rd_en, Bi_p0_rd_en);
        end
        total++;
        if (Ai_p0_addr_data !== 8'd0 || Bi_p0_addr_data !== 8'd0) begin
            bad++;
            $display("FAIL reset_rd_addr got=%0d,%0d want=0,0",
                     Ai_p0_addr_data, Bi_p0_addr_data);
        end
        total++;
        if (Co_p0_wr_en !== 1'b0 || Co_p0_addr_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_wr_en got=%b want=0", Co_p0_wr_en);
        end
        total++;
        if (Co_p0_addr_data !== 8'd0 || Co_p0_wr_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_wr_bus got=%0d,%0h want=0,0",
                     Co_p0_addr_data, Co_p0_wr_data);
        end
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL reset_done got=%b want=0", done);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_identity();
        for (int n = 0; n < 256; n++) begin
            amem[n] = (n / 16 == n % 16) ? 32'd1 : 32'd0;
            bmem[n] = n;
        end
        clear_log();
        pulse_start();
        wait_done(1, 5000);
        total++;
        if (done_q.size() != 1 || done_q[0] != 4609) begin
            bad++;
            $display("FAIL identity_done n=%0d cyc=%0d want=1,4609",
                     done_q.size(), done_q.size() ? done_q[0] : -1);
        end
        for (int n = 0; n < 256; n++) begin
            total++;
            if (cmem[n] !== 32'(n)) begin
                bad++;
                $display("FAIL identity_c[%0d] got=%0h want=%0h", n, cmem[n], n);
            end
        end
    endtask

    task automatic test_all_ones();
        fill_const(32'd1, 32'd1);
        clear_log();
        pulse_start();
        wait_done(1, 5000);
        total++;
        if (wr_cyc.size() != 256) begin
            bad++;
            $display("FAIL ones_wr_count got=%0d want=256", wr_cyc.size());
        end
        for (int n = 0; n < 256 && n < wr_cyc.size(); n++) begin
            total++;
            if (wr_cyc[n] != 18 + 18 * n || wr_addr[n] != n) begin
                bad++;
                $display("FAIL ones_wr[%0d] cyc=%0d addr=%0d want=%0d,%0d",
                         n, wr_cyc[n], wr_addr[n], 18 + 18 * n, n);
            end
        end
        total++;
        if (rd_cnt != 4096) begin
            bad++;
            $display("FAIL ones_rd_count got=%0d want=4096", rd_cnt);
        end
        total++;
        if (en_bad != 0) begin
            bad++;
            $display("FAIL ones_en_match got=%0d want=0", en_bad);
        end
        for (int n = 0; n < 256; n++) begin
            total++;
            if (cmem[n] !== 32'd16) begin
                bad++;
                $display("FAIL ones_c[%0d] got=%0h want=10", n, cmem[n]);
            end
        end
    endtask

    task automatic test_single();
        fill_const(32'd0, 32'd0);
        amem[0] = 32'd3;
        bmem[0] = 32'd5;
        clear_log();
        pulse_start();
        wait_done(1, 5000);
        for (int n = 0; n < 256; n++) begin
            total++;
            if (cmem[n] !== ((n == 0) ? 32'd15 : 32'd0)) begin
                bad++;
                $display("FAIL single_c[%0d] got=%0h want=%0h",
                         n, cmem[n], (n == 0) ? 15 : 0);
            end
        end
    endtask

    task automatic test_wrap(input logic [31:0] v, input logic [31:0] want);
        fill_const(v, v);
        clear_log();
        pulse_start();
        wait_done(1, 5000);
        for (int n = 0; n < 256; n++) begin
            total++;
            if (cmem[n] !== want) begin
                bad++;
                $display("FAIL wrap_%0h_c[%0d] got=%0h want=%0h",
                         v, n, cmem[n], want);
            end
        end
    endtask

    task automatic test_random();
        fill_random();
        compute_ref();
        clear_log();
        pulse_start();
        wait_done(1, 5000);
        total++;
        if (done_q.size() != 1) begin
            bad++;
            $display("FAIL random_done got=%0d want=1", done_q.size());
        end
        for (int n = 0; n < 256; n++) begin
            total++;
            if (cmem[n] !== cref[n]) begin
                bad++;
                $display("FAIL random_c[%0d] got=%0h want=%0h", n, cmem[n], cref[n]);
            end
        end
    endtask

    task automatic test_reset_mid();
        fill_random();
        clear_log();
        pulse_start();
        while (cyc - t0 < 100) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (300) @(negedge clk);
        total++;
        if (wr_cyc.size() != 5) begin
            bad++;
            $display("FAIL rstmid_wr_count got=%0d want=5", wr_cyc.size());
        end
        for (int n = 0; n < wr_cyc.size(); n++) begin
            total++;
            if (wr_cyc[n] >= 100) begin
                bad++;
                $display("FAIL rstmid_late_wr cyc=%0d want=<100", wr_cyc[n]);
            end
        end
        total++;
        if (done_q.size() != 0) begin
            bad++;
            $display("FAIL rstmid_done got=%0d want=0", done_q.size());
        end
        total++;
        if (Ai_p0_rd_en !== 1'b0 || Co_p0_wr_en !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_idle got=%b%b want=00", Ai_p0_rd_en, Co_p0_wr_en);
        end
        test_random();
    endtask

    task automatic test_extra_t();
        fill_random();
        compute_ref();
        clear_log();
        pulse_start();
        while (cyc - t0 < 500) @(negedge clk);
        t = 1'b1;
        @(negedge clk);
        t = 1'b0;
        wait_done(1, 5000);
        repeat (40) @(negedge clk);
        total++;
        if (done_q.size() != 1 || done_q[0] != 4609) begin
            bad++;
            $display("FAIL extra_t_done n=%0d want=1 at 4609", done_q.size());
        end
        total++;
        if (wr_cyc.size() != 256 || wr_cyc[255] != 4608) begin
            bad++;
            $display("FAIL extra_t_writes n=%0d want=256 last=4608", wr_cyc.size());
        end
        for (int n = 0; n < 256; n++) begin
            total++;
            if (cmem[n] !== cref[n]) begin
                bad++;
                $display("FAIL extra_t_c[%0d] got=%0h want=%0h", n, cmem[n], cref[n]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        fill_random();
        compute_ref();
        clear_log();
        @(negedge clk);
        t  = 1'b1;
        t0 = cyc;
        while (cyc - t0 < 4611) @(negedge clk);
        t = 1'b0;
        wait_done(2, 5000);
        repeat (60) @(negedge clk);
        total++;
        if (done_q.size() != 2 || done_q[0] != 4609 || done_q[1] != 9219) begin
            bad++;
            $display("FAIL b2b_done n=%0d want=2 at 4609,9219", done_q.size());
        end
        total++;
        if (wr_cyc.size() != 512) begin
            bad++;
            $display("FAIL b2b_wr_count got=%0d want=512", wr_cyc.size());
        end
        n0 = (wr_cyc.size() > 256) ? wr_cyc[256] : -1;
        total++;
        if (n0 != 4628) begin
            bad++;
            $display("FAIL b2b_second_first_wr got=%0d want=4628", n0);
        end
        for (int n = 0; n < 256; n++) begin
            total++;
            if (cmem[n] !== cref[n]) begin
                bad++;
                $display("FAIL b2b_c[%0d] got=%0h want=%0h", n, cmem[n], cref[n]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_all_ones();
        test_single();
        test_wrap(32'h0001_0000, 32'd0);
        test_wrap(32'hFFFF_FFFF, 32'd16);
        test_random();
        test_reset_mid();
        test_extra_t();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
